// File: rtl/accumulator_control_unit.sv
// Accumulator bank sequencer: tracks the skewed MAC output wavefront,
// drives per-bank write/add/mask per K-tile, then streams rows out.
module accumulator_control_unit #(
  parameter int MUL_SIZE  = 4,
  parameter int ACC_DEPTH = 128,
  parameter int PIPE_LAT  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                instruction_i,
  input  logic [8:0]          H_DIM_i,
  input  logic [7:0]          K_TILES_i,
  input  logic                MAC_compute_i,
  input  logic                stall_compute_i,
  input  logic                rd_ready_i,
  output logic                write_accumulator_o,
  output logic [6:0]          accumulator_addr_wr_o,
  output logic [MUL_SIZE-1:0] accum_addr_mask_o,
  output logic                accumulator_add_o,
  output logic                read_accumulator_o,
  output logic [6:0]          accumulator_addr_rd_o,
  output logic                busy_o,
  output logic                cfg_err_o,
  output logic                done_o
);

  typedef enum logic [1:0] {
    IDLE, ACCUM, READ, DONE
  } state_t;

  state_t              state;
  logic [PIPE_LAT-2:0] vline;
  logic [8:0]          h;
  logic [7:0]          k;
  logic [7:0]          tile;
  logic [7:0]          s;
  logic [6:0]          r;
  logic [MUL_SIZE-1:0] mask_n;
  logic                step;
  logic                last;
  logic                rlast;
  logic                cfg_ok;

  // The write strobe register is the final stage of the valid line,
  // so registered write outputs land exactly on mac_v.
  assign step   = (state == ACCUM) && vline[PIPE_LAT-2]
                  && !stall_compute_i;
  assign last   = {2'b0, s} == 10'(h) + 10'(MUL_SIZE - 2);
  assign rlast  = {2'b0, r} == h - 9'd1;
  assign busy_o = state != IDLE;
  assign cfg_ok = (H_DIM_i != 9'd0)
                  && (H_DIM_i <= 9'(ACC_DEPTH))
                  && (K_TILES_i != 8'd0);

  always_comb begin
    mask_n = '0;
    for (int c = 0; c < MUL_SIZE; c++) begin
      mask_n[c] = ({1'b0, s} >= 9'(c))
                  && (({1'b0, s} - 9'(c)) < h);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state                 <= IDLE;
      vline                 <= '0;
      h                     <= '0;
      k                     <= '0;
      tile                  <= '0;
      s                     <= '0;
      r                     <= '0;
      write_accumulator_o   <= 1'b0;
      accumulator_addr_wr_o <= '0;
      accum_addr_mask_o     <= '0;
      accumulator_add_o     <= 1'b0;
      read_accumulator_o    <= 1'b0;
      accumulator_addr_rd_o <= '0;
      cfg_err_o             <= 1'b0;
      done_o                <= 1'b0;
    end else begin
      write_accumulator_o <= 1'b0;
      accum_addr_mask_o   <= '0;
      read_accumulator_o  <= 1'b0;
      cfg_err_o           <= 1'b0;
      done_o              <= 1'b0;
      if (!stall_compute_i) begin
        vline <= (vline << 1)
                 | (PIPE_LAT-1)'(MAC_compute_i && state == ACCUM);
      end
      unique case (state)
        IDLE: begin
          if (instruction_i) begin
            if (cfg_ok) begin
              h     <= H_DIM_i;
              k     <= K_TILES_i;
              s     <= '0;
              tile  <= '0;
              r     <= '0;
              state <= ACCUM;
            end else begin
              cfg_err_o <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (step) begin
            write_accumulator_o   <= 1'b1;
            accumulator_addr_wr_o <= s[6:0];
            accum_addr_mask_o     <= mask_n;
            accumulator_add_o     <= tile != 8'd0;
            if (last) begin
              s <= '0;
              if (tile == k - 8'd1) state <= READ;
              else tile <= tile + 8'd1;
            end else begin
              s <= s + 8'd1;
            end
          end
        end
        READ: begin
          read_accumulator_o    <= rd_ready_i;
          accumulator_addr_rd_o <= r;
          if (rd_ready_i) begin
            r <= r + 7'd1;
            if (rlast) state <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Scoreboard bench for accumulator_control_unit: directed jobs push
// expected events; a negedge monitor pops and compares them.
module tb_accumulator_control_unit;

  typedef struct packed {
    logic [1:0] kind;
    logic [6:0] addr;
    logic [3:0] mask;
    logic       add;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr = 1'b0;
  logic [8:0] hdim = '0;
  logic [7:0] ktil = '0;
  logic       mac = 1'b0;
  logic       stall = 1'b0;
  logic       rdy = 1'b0;
  logic       wr;
  logic [6:0] addr_wr;
  logic [3:0] mask;
  logic       add;
  logic       rd;
  logic [6:0] addr_rd;
  logic       busy;
  logic       err;
  logic       done;

  ev_t  q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rd = -10;
  int   mac_cyc = 0;
  bit   lat_pending = 1'b0;

  logic [3:0] m3 [6] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
  logic [3:0] m1 [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic       pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  accumulator_control_unit #(
    .MUL_SIZE(4), .ACC_DEPTH(128), .PIPE_LAT(2)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .instruction_i         (instr),
    .H_DIM_i               (hdim),
    .K_TILES_i             (ktil),
    .MAC_compute_i         (mac),
    .stall_compute_i       (stall),
    .rd_ready_i            (rdy),
    .write_accumulator_o   (wr),
    .accumulator_addr_wr_o (addr_wr),
    .accum_addr_mask_o     (mask),
    .accumulator_add_o     (add),
    .read_accumulator_o    (rd),
    .accumulator_addr_rd_o (addr_rd),
    .busy_o                (busy),
    .cfg_err_o             (err),
    .done_o                (done)
  );

  function automatic ev_t mk(input logic [1:0] kd,
                             input logic [6:0] a,
                             input logic [3:0] m,
                             input logic ad);
    ev_t e;
    e.kind = kd;
    e.addr = a;
    e.mask = m;
    e.add  = ad;
    return e;
  endfunction

  function automatic void push_job(input int h, input int k);
    for (int t = 0; t < k; t++)
      for (int s = 0; s < h + 3; s++)
        q.push_back(mk(2'd0, 7'(s),
                       (h == 3) ? m3[s] : m1[s], t != 0));
    for (int r = 0; r < h; r++)
      q.push_back(mk(2'd1, 7'(r), 4'h0, 1'b0));
    q.push_back(mk(2'd2, 7'd0, 4'h0, 1'b0));
  endfunction

  task automatic check_ev(input ev_t act, input string nm);
    ev_t exp;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected got=%h", nm, act);
    end else begin
      exp = q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (wr) begin
        check_ev(mk(2'd0, addr_wr, mask, add), "write");
        if (lat_pending) begin
          lat_pending = 1'b0;
          checks++;
          if (cyc - mac_cyc != 2) begin
            errors++;
            $display("FAIL wr_latency got=%0d exp=2",
                     cyc - mac_cyc);
          end
        end
      end
      if (rd) begin
        check_ev(mk(2'd1, addr_rd, 4'h0, 1'b0), "read");
        last_rd = cyc;
      end
      if (done) begin
        check_ev(mk(2'd2, 7'd0, 4'h0, 1'b0), "done");
        checks++;
        if (last_rd != cyc - 1) begin
          errors++;
          $display("FAIL done_lat got=%0d exp=1",
                   cyc - last_rd);
        end
      end
      if (err) check_ev(mk(2'd3, 7'd0, 4'h0, 1'b0), "cfg_err");
    end
  end

  task automatic chk_zero(input string nm);
    logic [23:0] v;
    v = {wr, addr_wr, mask, add, rd, addr_rd, busy, err, done};
    checks++;
    if (v !== 24'h0) begin
      errors++;
      $display("FAIL %s got=%h exp=000000", nm, v);
    end
  endtask

  task automatic start(input int h, input int k);
    @(posedge clk); #1;
    instr = 1'b1;
    hdim  = 9'(h);
    ktil  = 8'(k);
    @(posedge clk); #1;
    instr = 1'b0;
  endtask

  task automatic mac_run(input int n, input int st_at,
                         input int st_len, input int ign_at);
    for (int i = 0; i < n + st_len; i++) begin
      mac   = 1'b1;
      stall = (i >= st_at) && (i < st_at + st_len);
      instr = (i == ign_at);
      if (i == ign_at) begin
        hdim = 9'd1;
        ktil = 8'd1;
      end
      if (i == 0) begin
        mac_cyc     = cyc + 1;
        lat_pending = 1'b1;
      end
      @(posedge clk); #1;
      if (stall) begin
        checks++;
        if ({wr, mask} !== 5'h0) begin
          errors++;
          $display("FAIL stall_gap got=%b exp=00000", {wr, mask});
        end
      end
    end
    mac   = 1'b0;
    stall = 1'b0;
    instr = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s timeout pending=%0d exp=0", nm, q.size());
    end
  endtask

  task automatic bad_start(input int h, input int k,
                           input string nm);
    q.push_back(mk(2'd3, 7'd0, 4'h0, 1'b0));
    start(h, k);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy got=%b exp=0", nm, busy);
    end
    @(posedge clk); #1;
    wait_idle(nm);
  endtask

  initial begin
    int n;
    #12;
    chk_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    rdy   = 1'b1;

    push_job(3, 1);
    start(3, 1);
    mac_run(6, -1, 0, -1);
    wait_idle("job_h3k1");

    push_job(3, 3);
    start(3, 3);
    mac_run(18, -1, 0, 5);
    wait_idle("job_h3k3");

    rdy = 1'b0;
    push_job(3, 1);
    start(3, 1);
    mac_run(6, 3, 2, -1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      rdy = pat[i];
      @(posedge clk); #1;
    end
    rdy = 1'b0;
    wait_idle("job_stall_toggle");
    rdy = 1'b1;

    push_job(1, 2);
    start(1, 2);
    mac_run(8, -1, 0, -1);
    wait_idle("job_h1k2");

    bad_start(0, 1, "h_zero");
    bad_start(129, 1, "h_big");
    bad_start(3, 0, "k_zero");

    for (int s = 0; s < 4; s++)
      q.push_back(mk(2'd0, 7'(s), m3[s], 1'b0));
    start(3, 1);
    mac = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL reset_wait timeout got=%0d exp=0", q.size());
    end
    rst_n = 1'b0;
    mac   = 1'b0;
    #1;
    chk_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_job(3, 1);
    start(3, 1);
    mac_run(6, -1, 0, -1);
    wait_idle("job_after_reset");

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover got=%0d exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
